bus_arb8: RTL and testbench
===========================

BUS_ARB8 -- requirements
Module: bus_arb8

Interface
REQ-001 The block SHALL expose parameter MAX_HOLD, default 16; maximum owned cycles before forced rotation (used only when ARB_HOLD_LIMIT_EN is defined; legal 2..255).
REQ-002 The block SHALL have port clk, input, 1, the single clock; every register is updated on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on the clk rising edge.
REQ-004 The block SHALL have port req, input, 8, per-requester request; a requester holds it high for the whole transaction.
REQ-005 The block SHALL have port gnt, output, 8, registered one-hot grant, or all-zero when no requester owns the resource.
REQ-006 The block SHALL have port sel, output, 3, registered binary index of the owner; it drives the select of the shared 8:1 32-bit result mux.
REQ-007 The block SHALL have port busy, output, 1, registered; high while any gnt bit is high.
REQ-008 The block SHALL have port revoke, output, 1, registered one-cycle pulse on forced preemption.

Function
REQ-009 The block SHALL implement a two-state FSM: IDLE (no owner) and OWN (one owner).
REQ-010 In IDLE with req != 0 at edge N, the block SHALL grant the winner at edge N, visible as gnt/sel/busy in cycle N+1 (1-cycle latency).
REQ-011 The winner SHALL be the first set req bit found searching upward from index ptr, wrapping 7->0.
REQ-012 On each grant, ptr SHALL become owner+1 mod 8.
REQ-013 In OWN, gnt and sel SHALL stay constant while req[owner]=1, regardless of other requests.
REQ-014 In OWN, when req[owner]=0 at an edge, the block SHALL move to IDLE with gnt=0 and busy=0, giving one idle bubble before the next grant.
REQ-015 In IDLE, sel SHALL hold its last value; gnt=0 gates the consumer.
REQ-016 Requests arriving or dropping while another requester owns the resource SHALL NOT change the current grant.
REQ-017 A requester whose req drops before it is granted SHALL lose its request; requests are not stored.
REQ-018 gnt SHALL always be one-hot or zero, and gnt[sel] SHALL equal busy.

Reset
REQ-019 While rst_n=0 at an edge, the block SHALL set: state=IDLE, gnt=0, sel=0, busy=0, revoke=0, ptr=0, hold counter=0.
REQ-020 Reset asserted during OWN SHALL drop the grant in the next cycle, with no revoke pulse.
REQ-021 After reset, requester 0 SHALL have the highest priority.

Configuration
REQ-022 With macro ARB_HOLD_LIMIT_EN defined, an 8-bit hold counter SHALL clear on grant and increment each OWN cycle.
REQ-023 With ARB_HOLD_LIMIT_EN defined, when the counter reaches MAX_HOLD-1 and any other req bit is set, the block SHALL go to IDLE: gnt=0 and revoke=1 for one cycle.
REQ-024 With ARB_HOLD_LIMIT_EN defined, if no other requester is pending at the limit, the owner SHALL keep the grant and the counter SHALL saturate.
REQ-025 With ARB_HOLD_LIMIT_EN undefined, the counter SHALL be absent, revoke SHALL be tied to 0, and ownership SHALL be unlimited.

Structure
REQ-026 A shared package arb_pkg SHALL hold the state encoding (IDLE=1'b0, OWN=1'b1), the N_REQ=8 and SEL_W=3 constants, and the MAX_HOLD default.
REQ-027 A combinational sub-module rr_pick8 SHALL take req[7:0] and ptr[2:0] and return found and idx[2:0]; bus_arb8 SHALL hold all registers.

Verification
REQ-028 The bench SHALL check: reset, then req=8'h00 for 5 cycles -> gnt=0, sel=0, busy=0 throughout.
REQ-029 The bench SHALL check: req=8'h81 applied together after reset -> gnt=8'h01, sel=0 one cycle later; drop req[0] -> one bubble, then gnt=8'h80, sel=7.
REQ-030 The bench SHALL check: req=8'hFF held, each owner releasing after 2 cycles -> grants follow the order 0,1,...,7,0, with one bubble between each.
REQ-031 The bench SHALL check: owner 3 holding while req[5] toggles -> gnt stays 8'h08 until req[3] drops.
REQ-032 The bench SHALL check: rst_n=0 during OWN with gnt=8'h10 -> next cycle gnt=0 and revoke=0; first grant after reset goes to the lowest set index.
REQ-033 With ARB_HOLD_LIMIT_EN defined and MAX_HOLD=4, the bench SHALL check: req[2] held and req[6] set -> gnt=8'h04 for 4 cycles, then revoke=1 and gnt=0, then gnt=8'h40.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way bus arbiter: state encoding, sizes and
// the hold-limit default (the limit itself is enabled by ARB_HOLD_LIMIT_EN).
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    localparam int N_REQ        = 8;
    localparam int SEL_W        = 3;
    localparam int MAX_HOLD_DEF = 16;

    function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] i);
        return N_REQ'(1) << i;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set req bit at or above ptr,
// wrapping 7->0.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[ptr + SEL_W'(i)]) begin
                found = 1'b1;
                idx   = ptr + SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_arb8.sv
// Round-robin owner arbiter for the shared 8:1 result mux. Define
// ARB_HOLD_LIMIT_EN to force rotation after MAX_HOLD owned cycles.
module bus_arb8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             revoke
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
        $error("bus_arb8: MAX_HOLD must be in 2..255");
    end

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             busy_q, busy_d;
    logic             found;
    logic [SEL_W-1:0] idx;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (found),
        .idx   (idx)
    );

`ifdef ARB_HOLD_LIMIT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       revoke_q, revoke_d;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
`ifdef ARB_HOLD_LIMIT_EN
        cnt_d    = cnt_q;
        revoke_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = OWN;
                    gnt_d   = onehot8(idx);
                    sel_d   = idx;
                    busy_d  = 1'b1;
                    ptr_d   = idx + SEL_W'(1);
`ifdef ARB_HOLD_LIMIT_EN
                    cnt_d   = '0;
`endif
                end
            end
            OWN: begin
                // sel keeps its value on release so the mux select stays quiet.
                if (!req[sel_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end
`ifdef ARB_HOLD_LIMIT_EN
                else if (cnt_q == HOLD_LAST && |(req & ~gnt_q)) begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    busy_d   = 1'b0;
                    revoke_d = 1'b1;
                end else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ARB_HOLD_LIMIT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            revoke_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            revoke_q <= revoke_d;
        end
    end
    assign revoke = revoke_q;
`else
    assign revoke = 1'b0;
`endif

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_bus_arb8.sv
// Directed bench for bus_arb8; the hold-limit scenario runs only when
// ARB_HOLD_LIMIT_EN is defined (DUT built with MAX_HOLD=4).
module tb_bus_arb8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       revoke;

    int nchk  = 0;
    int npass = 0;

    always #5 clk = ~clk;

    bus_arb8 #(.MAX_HOLD(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .gnt    (gnt),
        .sel    (sel),
        .busy   (busy),
        .revoke (revoke)
    );

    // Outputs observed as {gnt, sel, busy, revoke}.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [12:0] exp;
        do_reset();
        exp = {8'h00, 3'd0, 1'b0, 1'b0};
        nchk++;
        if ({gnt, sel, busy, revoke} !== exp)
            $display("FAIL reset_state got=%h want=%h", {gnt, sel, busy, revoke}, exp);
        else npass++;
        for (int i = 0; i < 5; i++) begin
            step();
            nchk++;
            if ({gnt, sel, busy, revoke} !== exp)
                $display("FAIL idle_no_req[%0d] got=%h want=%h", i, {gnt, sel, busy, revoke}, exp);
            else npass++;
        end
    endtask

    task automatic test_two_req();
        logic [12:0] exp;
        do_reset();
        req = 8'h81;
        step();
        exp = {8'h01, 3'd0, 1'b1, 1'b0};
        nchk++;
        if ({gnt, sel, busy, revoke} !== exp)
            $display("FAIL two_req_first got=%h want=%h", {gnt, sel, busy, revoke}, exp);
        else npass++;
        step();
        nchk++;
        if ({gnt, sel, busy, revoke} !== exp)
            $display("FAIL two_req_hold got=%h want=%h", {gnt, sel, busy, revoke}, exp);
        else npass++;
        req = 8'h80;
        step();
        exp = {8'h00, 3'd0, 1'b0, 1'b0};
        nchk++;
        if ({gnt, sel, busy, revoke} !== exp)
            $display("FAIL two_req_bubble got=%h want=%h", {gnt, sel, busy, revoke}, exp);
        else npass++;
        step();
        exp = {8'h80, 3'd7, 1'b1, 1'b0};
        nchk++;
        if ({gnt, sel, busy, revoke} !== exp)
            $display("FAIL two_req_second got=%h want=%h", {gnt, sel, busy, revoke}, exp);
        else npass++;
        req = 8'h00;
        step();
        exp = {8'h00, 3'd7, 1'b0, 1'b0};
        nchk++;
        if ({gnt, sel, busy, revoke} !== exp)
            $display("FAIL sel_holds_idle got=%h want=%h", {gnt, sel, busy, revoke}, exp);
        else npass++;
    endtask

    task automatic test_round_robin();
        logic [12:0] exp;
        logic [7:0]  g;
        do_reset();
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            g   = 8'h01 << (k % 8);
            exp = {g, 3'(k % 8), 1'b1, 1'b0};
            step();
            nchk++;
            if ({gnt, sel, busy, revoke} !== exp)
                $display("FAIL rr_grant[%0d] got=%h want=%h", k, {gnt, sel, busy, revoke}, exp);
            else npass++;
            step();
            nchk++;
            if ({gnt, sel, busy, revoke} !== exp)
                $display("FAIL rr_hold[%0d] got=%h want=%h", k, {gnt, sel, busy, revoke}, exp);
            else npass++;
            req = 8'hFF & ~g;
            step();
            exp = {8'h00, 3'(k % 8), 1'b0, 1'b0};
            nchk++;
            if ({gnt, sel, busy, revoke} !== exp)
                $display("FAIL rr_bubble[%0d] got=%h want=%h", k, {gnt, sel, busy, revoke}, exp);
            else npass++;
            req = 8'hFF;
        end
        req = 8'h00;
        step();
    endtask

    task automatic test_hold_steady();
        logic [12:0] exp;
        logic [7:0]  pat [3] = '{8'h28, 8'h08, 8'h28};
        do_reset();
        req = 8'h08;
        step();
        exp = {8'h08, 3'd3, 1'b1, 1'b0};
        nchk++;
        if ({gnt, sel, busy, revoke} !== exp)
            $display("FAIL steady_grant got=%h want=%h", {gnt, sel, busy, revoke}, exp);
        else npass++;
        for (int i = 0; i < 3; i++) begin
            req = pat[i];
            step();
            nchk++;
            if ({gnt, sel, busy, revoke} !== exp)
                $display("FAIL steady_toggle[%0d] got=%h want=%h", i, {gnt, sel, busy, revoke}, exp);
            else npass++;
        end
        req = 8'h20;
        step();
        exp = {8'h00, 3'd3, 1'b0, 1'b0};
        nchk++;
        if ({gnt, sel, busy, revoke} !== exp)
            $display("FAIL steady_release got=%h want=%h", {gnt, sel, busy, revoke}, exp);
        else npass++;
        step();
        exp = {8'h20, 3'd5, 1'b1, 1'b0};
        nchk++;
        if ({gnt, sel, busy, revoke} !== exp)
            $display("FAIL steady_next got=%h want=%h", {gnt, sel, busy, revoke}, exp);
        else npass++;
    endtask

    task automatic test_reset_own();
        logic [12:0] exp;
        do_reset();
        req = 8'h10;
        step();
        step();
        exp = {8'h10, 3'd4, 1'b1, 1'b0};
        nchk++;
        if ({gnt, sel, busy, revoke} !== exp)
            $display("FAIL rst_own_pre got=%h want=%h", {gnt, sel, busy, revoke}, exp);
        else npass++;
        rst_n = 1'b0;
        step();
        exp = {8'h00, 3'd0, 1'b0, 1'b0};
        nchk++;
        if ({gnt, sel, busy, revoke} !== exp)
            $display("FAIL rst_own_drop got=%h want=%h", {gnt, sel, busy, revoke}, exp);
        else npass++;
        rst_n = 1'b1;
        req   = 8'h14;
        step();
        exp = {8'h04, 3'd2, 1'b1, 1'b0};
        nchk++;
        if ({gnt, sel, busy, revoke} !== exp)
            $display("FAIL rst_first_low got=%h want=%h", {gnt, sel, busy, revoke}, exp);
        else npass++;
        req = 8'h00;
        step();
    endtask

`ifdef ARB_HOLD_LIMIT_EN
    task automatic test_hold_limit();
        logic [12:0] exp;
        do_reset();
        req = 8'h44;
        exp = {8'h04, 3'd2, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            step();
            nchk++;
            if ({gnt, sel, busy, revoke} !== exp)
                $display("FAIL limit_own[%0d] got=%h want=%h", i, {gnt, sel, busy, revoke}, exp);
            else npass++;
        end
        step();
        exp = {8'h00, 3'd2, 1'b0, 1'b1};
        nchk++;
        if ({gnt, sel, busy, revoke} !== exp)
            $display("FAIL limit_revoke got=%h want=%h", {gnt, sel, busy, revoke}, exp);
        else npass++;
        step();
        exp = {8'h40, 3'd6, 1'b1, 1'b0};
        nchk++;
        if ({gnt, sel, busy, revoke} !== exp)
            $display("FAIL limit_next got=%h want=%h", {gnt, sel, busy, revoke}, exp);
        else npass++;
        // Alone at the limit: owner keeps the grant, then yields once a rival appears.
        do_reset();
        req = 8'h04;
        exp = {8'h04, 3'd2, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) step();
        nchk++;
        if ({gnt, sel, busy, revoke} !== exp)
            $display("FAIL limit_saturate got=%h want=%h", {gnt, sel, busy, revoke}, exp);
        else npass++;
        req = 8'h44;
        step();
        exp = {8'h00, 3'd2, 1'b0, 1'b1};
        nchk++;
        if ({gnt, sel, busy, revoke} !== exp)
            $display("FAIL limit_late_rival got=%h want=%h", {gnt, sel, busy, revoke}, exp);
        else npass++;
        req = 8'h00;
        step();
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        test_reset();
        test_two_req();
        test_round_robin();
        test_hold_steady();
        test_reset_own();
`ifdef ARB_HOLD_LIMIT_EN
        test_hold_limit();
`endif
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
